// File: rtl/rv32i_pkg.sv
// Shared opcodes, FSM states and control encodings for the rv32i
// multi-cycle core: state, pc_src, wb_sel, fault and instruction class.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_ALU   = 2'd1
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_BUS     = 2'd1,
        FLT_ILLEGAL = 2'd2,
        FLT_ENV     = 2'd3
    } fault_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
        CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_FENCE, CL_SYSTEM
    } iclass_t;

    function automatic iclass_t decode_class(input logic [6:0] op);
        iclass_t c;
        case (op)
            OP_LUI:    c = CL_LUI;
            OP_AUIPC:  c = CL_AUIPC;
            OP_JAL:    c = CL_JAL;
            OP_JALR:   c = CL_JALR;
            OP_BRANCH: c = CL_BRANCH;
            OP_LOAD:   c = CL_LOAD;
            OP_STORE:  c = CL_STORE;
            OP_IMM:    c = CL_OPIMM;
            OP_OP:     c = CL_OP;
            OP_FENCE:  c = CL_FENCE;
            OP_SYSTEM: c = CL_SYSTEM;
            default:   c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter with clear/enable; timeout flags count == MEM_TIMEOUT-1.
// Ports: clk, rst (async high), clear, en -> timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic timeout
);

    localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // Holds at LAST; the FSM leaves the waiting state on that cycle anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the rv32i core: fetch/decode/exec/mem/wb,
// memory handshake with timeout, trap/halt state and instret counter.
// Ports: clk, rst, opcode, branch_taken, mem_ready -> datapath enables,
// selects, mem_req/mem_we/mem_addr_sel, retire, halted, fault, instret.
module core_sequencer
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             retire,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    state_t  state, next_state;
    iclass_t class_q, class_d;
    fault_t  fault_q, fault_d;

    logic tmr_en, tmr_clear, timeout;
    logic sel_a, sel_b;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .timeout (timeout)
    );

    // Clear on entry to a new state and on every completed handshake.
    assign tmr_clear = (next_state != state) || mem_ready;

    // Operand selects follow the latched class and stay put through MEM/WB.
    assign sel_a = (class_q == CL_AUIPC) || (class_q == CL_JAL) ||
                   (class_q == CL_BRANCH);
    assign sel_b = (class_q != CL_OP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            class_q <= CL_ILLEGAL;
            fault_q <= FLT_NONE;
        end else begin
            state   <= next_state;
            class_q <= class_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        next_state   = state;
        class_d      = class_q;
        fault_d      = fault_q;
        tmr_en       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        retire       = 1'b0;

        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    next_state = DECODE;
                end else if (timeout) begin
                    next_state = TRAP;
                    fault_d    = FLT_BUS;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DECODE: begin
                class_d = decode_class(opcode);
                if (class_d == CL_ILLEGAL) begin
                    next_state = TRAP;
                    fault_d    = FLT_ILLEGAL;
                end else if (class_d == CL_SYSTEM) begin
                    next_state = TRAP;
                    fault_d    = FLT_ENV;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                unique case (class_q)
                    CL_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_src     = branch_taken ? PC_ALU : PC_PLUS4;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    CL_FENCE: begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    CL_LOAD, CL_STORE: next_state = MEM;
                    default:           next_state = WB;
                endcase
            end
            MEM: begin
                alu_a_sel    = sel_a;
                alu_b_sel    = sel_b;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (class_q == CL_STORE);
                if (mem_ready) begin
                    if (class_q == CL_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end else if (timeout) begin
                    next_state = TRAP;
                    fault_d    = FLT_BUS;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WB: begin
                alu_a_sel = sel_a;
                alu_b_sel = sel_b;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                if (class_q == CL_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (class_q == CL_JAL || class_q == CL_JALR) begin
                    wb_sel = WB_PC4;
                    pc_src = PC_ALU;
                end
                next_state = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // Nothing may reach the datapath or the bus while reset is held.
        if (rst) begin
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = PC_PLUS4;
            rf_we        = 1'b0;
            wb_sel       = WB_ALU;
            alu_a_sel    = 1'b0;
            alu_b_sel    = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            retire       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

    assign halted = (state == TRAP);
    assign fault  = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instructions push
// expected retire behaviour; a negedge monitor pops and compares.
module tb_core_sequencer;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel;
    logic        mem_req, mem_we, mem_addr_sel, retire, halted;
    logic [1:0]  pc_src, wb_sel, fault;
    logic [31:0] instret;

    core_sequencer #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .retire       (retire),
        .halted       (halted),
        .fault        (fault),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       rf;
        logic       mwe;
        logic [1:0] wb;
        logic [1:0] pcs;
        int         lat;
        int         cnt;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   rcnt   = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: offset counts cycles since the ir_we cycle of the instruction.
    initial begin
        int   ofs;
        exp_t e;
        ofs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ofs = -100;
            end else begin
                if (ir_we) ofs = 0;
                else ofs = ofs + 1;
                if (expq.size() == 0) begin
                    chk("idle_retire_rf_we", {30'd0, retire, rf_we}, 32'd0);
                end else begin
                    e = expq[0];
                    if (ofs == 2) begin
                        chk("exec_alu_a_sel", alu_a_sel, e.a);
                        chk("exec_alu_b_sel", alu_b_sel, e.b);
                    end
                    if (mem_req && mem_addr_sel)
                        chk("mem_phase_we", mem_we, e.mwe);
                    if (retire) begin
                        void'(expq.pop_front());
                        chk("retire_latency", ofs, e.lat);
                        chk("retire_rf_we", rf_we, e.rf);
                        chk("retire_wb_sel", wb_sel, e.wb);
                        chk("retire_pc_we", pc_we, 1);
                        chk("retire_pc_src", pc_src, e.pcs);
                        chk("retire_instret", instret, e.cnt - 1);
                    end
                end
                if (retire) rcnt++;
            end
        end
    end

    task automatic run(input logic [6:0] op, input logic bt, input int mw,
                       input logic ea, input logic eb, input logic erf,
                       input logic [1:0] ewb, input logic [1:0] epcs,
                       input logic emwe, input int lat);
        exp_t e;
        int   target;
        exp_cnt++;
        e.a = ea;  e.b = eb;  e.rf = erf;  e.mwe = emwe;
        e.wb = ewb;  e.pcs = epcs;  e.lat = lat;  e.cnt = exp_cnt;
        opcode = op;
        branch_taken = bt;
        mem_ready = 1'b1;
        expq.push_back(e);
        target = rcnt + 1;
        if (mw > 0) begin
            @(posedge clk); #1 mem_ready = 1'b0;
            repeat (2 + mw) @(posedge clk);
            #1 mem_ready = 1'b1;
        end
        for (int i = 0; i < 40 && rcnt < target; i++) @(posedge clk);
        chk("retire_seen", rcnt >= target, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        opcode = OP_IMM;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_addr_sel", mem_addr_sel, 0);

        //  op         bt mw a  b  rf wb pcs mwe lat
        run(OP_IMM,    0, 0, 0, 1, 1, 0, 0, 0, 3);
        run(OP_LOAD,   0, 0, 0, 1, 1, 1, 0, 0, 4);
        run(OP_STORE,  0, 0, 0, 1, 0, 0, 0, 1, 3);
        run(OP_BRANCH, 1, 0, 1, 1, 0, 0, 1, 0, 2);
        run(OP_BRANCH, 0, 0, 1, 1, 0, 0, 0, 0, 2);
        run(OP_JAL,    0, 0, 1, 1, 1, 2, 1, 0, 3);
        run(OP_JALR,   0, 0, 0, 1, 1, 2, 1, 0, 3);
        run(OP_LUI,    0, 0, 0, 1, 1, 0, 0, 0, 3);
        run(OP_AUIPC,  0, 0, 1, 1, 1, 0, 0, 0, 3);
        run(OP_OP,     0, 0, 0, 0, 1, 0, 0, 0, 3);
        run(OP_FENCE,  0, 0, 0, 1, 0, 0, 0, 0, 2);
        run(OP_LOAD,   0, 2, 0, 1, 1, 1, 0, 0, 6);
        run(OP_STORE,  0, 1, 0, 1, 0, 0, 0, 1, 4);
        chk("instret_total", instret, exp_cnt);

        // Reset in the middle of a stalled load.
        opcode = OP_LOAD;
        mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_mem_req_before", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_addr_sel", mem_addr_sel, 0);
        chk("abort_rf_we", rf_we, 0);
        chk("abort_instret", instret, 0);
        exp_cnt = 0;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("rel_mem_req", mem_req, 1);
        chk("rel_addr_sel", mem_addr_sel, 0);
        run(OP_IMM,    0, 0, 0, 1, 1, 0, 0, 0, 3);
        chk("instret_after_abort", instret, 1);

        // Fetch timeout with MEM_TIMEOUT=8.
        rst = 1'b1;
        #1;
        @(posedge clk); #1 rst = 1'b0;
        mem_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("tmo_edge_halted", halted, 0);
        chk("tmo_edge_mem_req", mem_req, 1);
        @(posedge clk); #1;
        chk("tmo_halted", halted, 1);
        chk("tmo_fault", fault, 1);
        chk("tmo_mem_req", mem_req, 0);
        mem_ready = 1'b1;
        #1;
        chk("tmo_ignore_ir_we", ir_we, 0);
        @(posedge clk); #1 mem_ready = 1'b0;
        chk("tmo_still_halted", halted, 1);
        chk("tmo_fault_held", fault, 1);
        chk("tmo_instret", instret, 0);

        // Illegal opcode and ECALL traps from DECODE.
        for (int k = 0; k < 2; k++) begin
            rst = 1'b1;
            #1;
            @(posedge clk); #1 rst = 1'b0;
            opcode = (k == 0) ? 7'b0000000 : OP_SYSTEM;
            mem_ready = 1'b1;
            @(posedge clk); #1;
            chk("dec_halted", halted, 0);
            chk("dec_fault", fault, 0);
            @(posedge clk); #1;
            chk("trap_fault", fault, (k == 0) ? 2 : 3);
            chk("trap_halted", halted, 1);
            chk("trap_mem_req", mem_req, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the rv32i core. It sequences the shared datapath (PC, IR, register file, ALU, single memory port) through fetch, decode, execute, memory and writeback for each instruction. It sits in `top` between the instruction register and the datapath muxes and enables. It owns the memory request handshake, the trap/halt state and the retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, maximum memory wait cycles before a bus fault (≥2).
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous active-high reset.
opcode  in  7  IR[6:0], stable from DECODE until the next FETCH.
branch_taken  in  1  branch comparator result, valid in EXEC.
mem_ready  in  1  memory completes the current request this cycle.
ir_we  out  1  load IR from memory read data.
pc_we  out  1  update PC.
pc_src  out  2  0 = PC+4, 1 = ALU result (JAL/JALR/taken branch target).
rf_we  out  1  register file write (x0 discard is handled by the regfile).
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
alu_a_sel  out  1  0 = rs1, 1 = PC.
alu_b_sel  out  1  0 = rs2, 1 = immediate.
mem_req  out  1  memory request valid.
mem_we  out  1  store request (only meaningful with mem_req).
mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store).
retire  out  1  one-cycle pulse per completed instruction.
halted  out  1  sticky, core stopped.
fault  out  2  0 = none, 1 = bus timeout, 2 = illegal opcode, 3 = ECALL/EBREAK.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, any state): state = FETCH; class reg, wait counter and instret = 0; halted = 0; fault = 0. All outputs derived from FETCH with mem_ready low (mem_req=1 only after rst deasserts; while rst=1 force all enables/req to 0).
- Control outputs are combinational from state, latched class, mem_ready and branch_taken. Every output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1, assert ir_we and go to DECODE. Otherwise increment wait counter.
- DECODE: capture opcode class. LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE and SYSTEM are legal. Any other opcode → TRAP with fault=2. SYSTEM → TRAP with fault=3. Otherwise → EXEC.
- EXEC: set ALU operand selects:
  - AUIPC/JAL/BRANCH: a=PC, b=imm.
  - OP: a=rs1, b=rs2.
  - LUI: b=imm (the ALU passes imm).
  - Others: a=rs1, b=imm.
- EXEC next state:
  - BRANCH: pc_we=1, pc_src = branch_taken; retire; → FETCH.
  - FENCE: pc_we=1, pc_src=0; retire; → FETCH.
  - LOAD/STORE: → MEM.
  - Otherwise: → WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE); operand selects are held. On mem_ready:
  - STORE: pc_we=1, pc_src=0; retire; → FETCH.
  - LOAD: → WB.
- WB: rf_we=1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_we=1; pc_src=1 for JAL/JALR, else 0.
  - retire; → FETCH.
- Memory handshake:
  - mem_req holds with stable we/addr_sel until the cycle mem_ready=1.
  - mem_ready outside FETCH/MEM is ignored.
  - The wait counter clears on state entry and on ready.
  - If the counter reaches MEM_TIMEOUT−1 with mem_ready still 0 → TRAP, fault=1. No ir_we, pc_we or retire is issued for that instruction.
- TRAP: halted=1 and fault hold until reset; all enables and mem_req are 0.
- instret increments on each retire cycle and wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - 3 cycles: branch, FENCE.
  - 4 cycles: ALU ops, LUI, AUIPC, JAL, JALR, store.
  - 5 cycles: load.
  - Each memory wait cycle adds one.

Decomposition:
- rv32i_pkg holds:
  - opcode localparams;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - pc_src, wb_sel and fault enums;
  - the instruction-class enum.
- One sub-module, mem_wait_timer: counter with clear/enable and a timeout flag at MEM_TIMEOUT−1.

Test Plan:
1. ADDI (0010011), mem_ready tied 1 → ir_we in cycle 0; rf_we=1, wb_sel=0, pc_we=1, pc_src=0, retire in cycle 3; instret=1.
2. LW then SW, ready=1 → LW: mem_we=0, addr_sel=1 in cycle 3, rf_we with wb_sel=1 in cycle 4. SW: mem_we=1 and retire in cycle 3. instret=2 after 9 cycles.
3. BEQ with branch_taken=1, then 0 → pc_src=1 and then 0 in the EXEC cycle (cycle 2); 3-cycle retire; rf_we never asserted.
4. JAL → EXEC a=PC, b=imm; WB: wb_sel=2, pc_src=1, rf_we=1.
5. MEM_TIMEOUT=8, mem_ready held 0 in FETCH for 8 cycles → halted=1, fault=1, mem_req=0 afterwards. A later mem_ready pulse has no effect. An opcode of 0000000 in a separate run → fault=2 from DECODE.
6. Assert rst mid-MEM of a load with ready low → outputs drop to 0 asynchronously; instret=0. After release: FETCH with mem_req=1; no rf_we is issued for the aborted load.
